// File: rtl/c17_bist.sv
// BIST engine for the c17 benchmark: exhaustive 5-bit stimulus, 16-bit MISR compaction and
// golden-signature compare, with a start/busy/done handshake toward a test sequencer.
module c17_bist #(
  parameter int unsigned NUM_PATTERNS = 32,
  parameter logic [15:0] SEED         = 16'h0000,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  cut_out,
  output logic [4:0]  cut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 32) begin : gen_bad_cfg
    $fatal(1, "c17_bist: NUM_PATTERNS must be in 1..32");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  localparam logic [4:0] LastPat = 5'(NUM_PATTERNS - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cut_in_q, cut_in_d;
  logic [15:0] sig_q, sig_d;
  logic        primed_q, primed_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] misr_next;

  assign misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {14'b0, cut_out};

  always_comb begin
    state_d  = state_q;
    cut_in_d = cut_in_q;
    sig_d    = sig_q;
    primed_d = primed_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          sig_d    = SEED;
          cut_in_d = 5'd0;
          pass_d   = 1'b0;
          primed_d = 1'b0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d  = StIdle;
          cut_in_d = 5'd0;
          primed_d = 1'b0;
        end else if (!primed_q) begin
          // First RUN cycle only settles pattern 0 through the CUT; nothing is compacted yet.
          primed_d = 1'b1;
        end else begin
          sig_d = misr_next;
          if (cut_in_q == LastPat) begin
            state_d = StCheck;
          end else begin
            cut_in_d = cut_in_q + 5'd1;
          end
        end
      end
      StCheck: begin
        pass_d   = (sig_q == GOLDEN);
        done_d   = 1'b1;
        cut_in_d = 5'd0;
        primed_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d  = StIdle;
        cut_in_d = 5'd0;
        primed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cut_in_q <= 5'd0;
      sig_q    <= 16'h0000;
      primed_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cut_in_q <= cut_in_d;
      sig_q    <= sig_d;
      primed_q <= primed_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign cut_in    = cut_in_q;
  assign busy      = (state_q == StRun) || (state_q == StCheck);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_c17_bist.sv
// Directed bench for c17_bist: pattern trace, stuck-at CUT, full run against a c17+MISR
// reference, handshake corner cases, abort and asynchronous reset.
module tb_c17_bist;

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n10, n11, n16, n19;
    n10 = ~(x[4] & x[2]);
    n11 = ~(x[2] & x[1]);
    n16 = ~(x[3] & n11);
    n19 = ~(n11 & x[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] o);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, o};
  endfunction

  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < n; k++) s = misr_step(s, c17(5'(k)));
    return s;
  endfunction

  localparam logic [15:0] GoldFull = model_sig(32);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_w = 1'b0;
  logic abort = 1'b0;

  logic [4:0]  ci_a, ci_b, ci_c, ci_d;
  logic [1:0]  co_a, co_b, co_c, co_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic        pass_a, pass_b, pass_c, pass_d;
  logic [15:0] sig_a, sig_b, sig_c, sig_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign co_a = c17(ci_a);
  assign co_b = 2'b00;
  assign co_c = c17(ci_c);
  assign co_d = c17(ci_d);

  c17_bist #(.NUM_PATTERNS(2), .SEED(16'h0000), .GOLDEN(16'h0001)) u_trace (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(1'b0), .cut_out(co_a),
    .cut_in(ci_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  c17_bist #(.NUM_PATTERNS(32), .SEED(16'h0000), .GOLDEN(16'h1234)) u_stuck (
    .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort), .cut_out(co_b),
    .cut_in(ci_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  c17_bist #(.NUM_PATTERNS(32), .SEED(16'h0000), .GOLDEN(GoldFull)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort), .cut_out(co_c),
    .cut_in(ci_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c)
  );

  c17_bist #(.NUM_PATTERNS(32), .SEED(16'h0000), .GOLDEN(GoldFull ^ 16'h0100)) u_flip (
    .clk(clk), .rst_n(rst_n), .start(start_w), .abort(abort), .cut_out(co_d),
    .cut_in(ci_d), .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at;
    bit found;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cut_in", 32'(ci_c), 32'h0);
    check_eq("rst_busy", 32'(busy_c), 32'h0);
    check_eq("rst_done", 32'(done_c), 32'h0);
    check_eq("rst_pass", 32'(pass_c), 32'h0);
    check_eq("rst_sig", 32'(sig_c), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("idle_busy", 32'(busy_c), 32'h0);

    // Pattern trace, N=2
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_eq("tr_e0_busy", 32'(busy_a), 32'h1);
    check_eq("tr_e0_cut_in", 32'(ci_a), 32'h0);
    tick();
    check_eq("tr_e1_cut_in", 32'(ci_a), 32'h0);
    check_eq("tr_e1_cut_out", 32'(co_a), 32'h0);
    tick();
    check_eq("tr_e2_cut_in", 32'(ci_a), 32'h1);
    check_eq("tr_e2_cut_out", 32'(co_a), 32'h1);
    tick();
    check_eq("tr_e3_busy", 32'(busy_a), 32'h1);
    check_eq("tr_e3_done", 32'(done_a), 32'h0);
    tick();
    check_eq("tr_e4_done", 32'(done_a), 32'h1);
    check_eq("tr_e4_busy", 32'(busy_a), 32'h0);
    check_eq("tr_e4_pass", 32'(pass_a), 32'h1);
    check_eq("tr_e4_sig", 32'(sig_a), 32'h0001);
    tick();
    check_eq("tr_e5_done", 32'(done_a), 32'h0);

    // N=32 runs; a stray start pulse mid-run must be ignored
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check_eq("full_e0_cut_in", 32'(ci_c), 32'h0);
    check_eq("full_e0_sig", 32'(sig_c), 32'h0);
    busy_cnt = busy_b ? 1 : 0;
    done_cnt = 0;
    done_at = -1;
    for (int i = 1; i <= 40; i++) begin
      start_w = (i == 5);
      tick();
      if (i <= 32) check_eq($sformatf("full_cut_in_%0d", i - 1), 32'(ci_c), 32'(i - 1));
      if (busy_b) busy_cnt++;
      if (done_c) done_cnt++;
      if (done_b && done_at < 0) done_at = i;
    end
    start_w = 1'b0;
    check_eq("stuck_busy_cycles", 32'(busy_cnt), 32'd34);
    check_eq("stuck_done_edge", 32'(done_at), 32'd34);
    check_eq("stuck_sig", 32'(sig_b), 32'h0000);
    check_eq("stuck_pass", 32'(pass_b), 32'h0);
    check_eq("full_done_count", 32'(done_cnt), 32'd1);
    check_eq("full_sig", 32'(sig_c), 32'(GoldFull));
    check_eq("full_pass", 32'(pass_c), 32'h1);
    check_eq("flip_sig", 32'(sig_d), 32'(GoldFull));
    check_eq("flip_pass", 32'(pass_d), 32'h0);

    // start held through done: next run begins with no idle gap
    start_w = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (done_c) found = 1'b1;
    end
    check_eq("b2b_done_seen", 32'(found), 32'h1);
    check_eq("b2b_pass_at_done", 32'(pass_c), 32'h1);
    tick();
    start_w = 1'b0;
    check_eq("b2b_busy", 32'(busy_c), 32'h1);
    check_eq("b2b_pass_cleared", 32'(pass_c), 32'h0);
    check_eq("b2b_cut_in", 32'(ci_c), 32'h0);

    // Abort when cut_in reaches 10
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (ci_c == 5'd10) found = 1'b1;
    end
    check_eq("abort_wait_cut10", 32'(found), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy_c), 32'h0);
    check_eq("abort_cut_in", 32'(ci_c), 32'h0);
    check_eq("abort_sig", 32'(sig_c), 32'(model_sig(10)));
    check_eq("abort_pass", 32'(pass_c), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_c) done_cnt++;
    end
    check_eq("abort_no_done", 32'(done_cnt), 32'h0);
    check_eq("abort_sig_hold", 32'(sig_c), 32'(model_sig(10)));

    // Asynchronous reset mid-run
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    repeat (14) tick();
    check_eq("pre_rst_busy", 32'(busy_c), 32'h1);
    check_eq("pre_rst_sig", 32'(sig_c), 32'(model_sig(13)));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy_c), 32'h0);
    check_eq("arst_cut_in", 32'(ci_c), 32'h0);
    check_eq("arst_sig", 32'(sig_c), 32'h0);
    check_eq("arst_pass_trace", 32'(pass_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("post_rst_busy", 32'(busy_c), 32'h0);
    check_eq("post_rst_cut_in", 32'(ci_c), 32'h0);
    check_eq("post_rst_done", 32'(done_c), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c17_bist.md
# c17_bist

Built-in self-test engine that drives the c17 benchmark circuit and checks its responses. It applies an exhaustive 5-bit pattern sequence to the c17 inputs and compacts the two c17 outputs into a 16-bit MISR signature. At the end of the run it compares the signature against a golden value. It sits beside the c17 instance in the test harness and handshakes with a test sequencer through start/busy/done.

## Interface
- NUM_PATTERNS, 32: patterns applied per run. Legal range 1..32. Patterns are 0..NUM_PATTERNS-1.
- SEED, 16'h0000: MISR value loaded at run start.
- GOLDEN, 16'h0000: expected final signature.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous abort; sampled only in RUN.
- cut_out  in  2  c17 responses: [1]=output 22, [0]=output 23. Combinational from cut_in.
- cut_in  out  5  registered c17 stimulus: [4]=input 1, [3]=2, [2]=3, [1]=6, [0]=7.
- busy  out  1  high in RUN and CHECK.
- done  out  1  one-cycle completion pulse.
- pass  out  1  signature==GOLDEN for the last completed run. Held until the next start.
- signature  out  16  current or final MISR value.

## Operation
- States: IDLE, RUN, CHECK.
- IDLE:
  - cut_in=0, busy=0.
  - If start=1: go to RUN, load signature<=SEED, cut_in<=0, clear pass<=0.
- RUN, per cycle:
  - Update signature<=misr(signature, cut_out).
  - If abort=1: go to IDLE. The signature update is suppressed, no done, pass stays 0, cut_in<=0.
  - Else if cut_in==NUM_PATTERNS-1: go to CHECK.
  - Else: cut_in<=cut_in+1.
- MISR step:
  - next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {14'b0, cut_out}.
  - Polynomial x^16+x^12+x^5+1.
  - No carry out; bits shifted out of [15] are discarded.
- CHECK:
  - Registers pass<=(signature==GOLDEN), done<=1, cut_in<=0.
  - Goes to IDLE. signature holds.
- done:
  - High exactly one cycle, the first IDLE cycle after CHECK.
  - In that cycle start is honoured, so back-to-back runs are allowed.
- start is ignored while busy=1. abort is ignored outside RUN.
- Pattern counter width is 5 bits; it never wraps because N≤32 bounds the terminal compare.
- Out-of-range NUM_PATTERNS (0 or >32) is a configuration error. An elaboration-time assertion catches it.

## Timing
- Reset (async assert, sync release): state=IDLE, cut_in=0, busy=0, done=0, pass=0, signature=0.
- Asserting rst_n=0 mid-run clears all outputs immediately, with no clock edge required.
- Edge E0: start sampled in IDLE. After E0: busy=1, cut_in=0, signature=SEED.
- Pattern k (0..N-1):
  - Driven on cut_in in the cycle after edge E(k+1).
  - cut_out for pattern k is absorbed at edge E(k+2).
- After edge E(N+1): state=CHECK.
- After edge E(N+2): done=1, busy=0, pass valid, signature final.
- Start-to-done latency is N+2 cycles. With N=32 that is 34 cycles.
- Abort sampled at edge Ea: busy=0 after Ea. The pattern driven during that cycle is not compacted.

## Test plan
- Pattern trace: N=2, SEED=0, GOLDEN=16'h0001, real c17.
  - start at E0 -> cut_in=5'd0 then 5'd1.
  - cut_out=2'b00 then 2'b01.
  - signature=16'h0001, done pulse after E4, pass=1.
- Stuck-at fault: c17 replaced by a stuck-at-0 model (cut_out=2'b00), N=32, SEED=0, GOLDEN=16'h1234.
  - signature=16'h0000, pass=0, done after E34, busy high for exactly 34 cycles.
- Full run: N=32 against a bench reference model of c17 plus MISR.
  - cut_in steps 0..31, one per cycle.
  - signature matches the model.
  - pass=1 when GOLDEN is set to the model value; pass=0 with any single-bit GOLDEN flip.
- Handshake:
  - start pulsed while busy -> no effect on cut_in, cycle count or signature.
  - start held high through done -> the second run starts with no idle gap, pass cleared to 0 in the cycle after done.
- Abort:
  - abort at the edge where cut_in=5'd10 -> busy=0 next cycle, cut_in=0, done never pulses, pass=0, signature holds its pre-abort value.
- Reset: rst_n=0 asynchronously mid-cycle during RUN -> all outputs 0 before the next edge. After release, the block sits in IDLE until start.
